word_arbiter_2: RTL and testbench
=================================

// Module: word_arbiter_2
// PURPOSE
//  Two-requester round-robin arbiter that shares one 32-bit word path, the 2:1 word mux stage, between two producers.
//  Drives the mux select (sel) and holds it for a whole burst (until last or MAX_BEATS beats).
//  Adds a registered output stage with valid/ready handshake. Sits between two producers and one downstream consumer.
// PARAMETERS
//  WIDTH      32  data word width
//  MAX_BEATS  16  max beats per grant before forced release (>=1); beat counter width = clog2(MAX_BEATS)+1
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  i0_valid   in   1      requester 0 has a beat
//  i0_data    in   WIDTH  requester 0 word
//  i0_last    in   1      requester 0 final beat of burst
//  i0_ready   out  1      beat from requester 0 accepted this cycle
//  i1_valid   in   1      requester 1 has a beat
//  i1_data    in   WIDTH  requester 1 word
//  i1_last    in   1      requester 1 final beat of burst
//  i1_ready   out  1      beat from requester 1 accepted this cycle
//  sel        out  1      mux select / current owner (0 = I0, 1 = I1)
//  busy       out  1      a grant is active
//  c_valid    out  1      output word valid
//  c_data     out  WIDTH  output word
//  c_last     out  1      output word ends its burst (real last or forced)
//  c_ready    in   1      consumer accepts output word
// BEHAVIOUR
//  Reset: state IDLE, sel=0, busy=0, c_valid=0, c_data=0, c_last=0, beat_cnt=0, prio=0 (req 0 favoured). Reset overrides all events.
//  States: IDLE, BUSY (registered; busy = state==BUSY).
//  IDLE: i*_ready=0.
//   - Only one valid: grant that requester.
//   - Both valid: grant the requester indicated by prio.
//   - On grant: sel <= winner, state <= BUSY, beat_cnt <= 0.
//   - No valid: stay IDLE.
//   - Arbitration costs 1 cycle; first beat can transfer in the cycle after the grant.
//  BUSY: space = !c_valid || c_ready.
//   - Granted requester ready = space; other requester ready = 0.
//   - Beat fires when granted valid && ready; then c_data <= data, c_valid <= 1, beat_cnt++.
//   - c_last <= i_last || (beat_cnt == MAX_BEATS-1).
//   - If the fired beat has c_last set: state <= IDLE, prio <= ~sel.
//   - sel is unchanged until the next grant.
//   - Granted requester drops valid mid-burst: grant held indefinitely; no timeout on idle cycles.
//  Output register: c_valid cleared when c_ready && c_valid and no new beat fires that cycle.
//   - Fire and drain in the same cycle: c_valid stays 1 with the new word.
//   - c_data/c_last hold while c_valid && !c_ready.
//  Latency: input beat -> c_valid: 1 cycle. Full throughput (1 beat/cycle) while c_ready=1.
//  Ungranted requester is never accepted, even if c_valid=0.
//  MAX_BEATS=1: every beat is a burst; grants alternate under contention.
// TESTING
//  1. After reset, both valid, no last -> IDLE 1 cycle; sel=0; 16 beats from i0, 16th has c_last=1; then sel=1 after 1 idle cycle.
//  2. Only i1_valid, data 0xA5A5_0001..0003, last on 3rd -> c_data same order, 1-cycle latency, c_last on 0x..0003, busy drops.
//  3. c_ready held low 3 cycles mid-burst -> c_data stable, i0_ready=0 while c_valid=1; resumes with no loss or duplication.
//  4. Alternating bursts, both always valid, last on every 2nd beat -> grant order 0,1,0,1; prio toggles on each release.
//  5. rst asserted mid-burst with c_valid=1 -> next cycle c_valid=0, sel=0, busy=0, both readies 0.
//  6. Granted i0 drops valid for 5 cycles mid-burst, i1 valid -> i1_ready stays 0, sel stays 0 until i0 sends last.

Source files
------------

// File: rtl/word_arbiter_2_if.sv
// ============================================================================
// Module   : word_arbiter_2_if
// Brief    : Word-stream handshake bundle (valid/data/last/ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface word_arbiter_2_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             ready;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/word_arbiter_2.sv
// ============================================================================
// Module   : word_arbiter_2
// Brief    : Two-requester round-robin burst arbiter over a shared word path,
//            with a registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_arbiter_2 #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  word_arbiter_2_if.slave  i0,
  word_arbiter_2_if.slave  i1,
  word_arbiter_2_if.master c,
  output logic            sel,
  output logic            busy
);

  localparam int                 CNT_W       = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0]   C_LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [0:0]         S_IDLE      = 1'b0;
  localparam logic [0:0]         S_BUSY      = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_sel;
  logic             r_prio;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_c_valid;
  logic [WIDTH-1:0] r_c_data;
  logic             r_c_last;

  logic             w_grant;
  logic             w_winner;
  logic             w_space;
  logic             w_g_valid;
  logic             w_g_ready;
  logic             w_g_last;
  logic [WIDTH-1:0] w_g_data;
  logic             w_fire;
  logic             w_last_out;
  logic             w_i0_ready;
  logic             w_i1_ready;

  // Contention goes to prio; a lone requester wins regardless of prio.
  assign w_winner   = (i0.valid && i1.valid) ? r_prio : i1.valid;
  assign w_grant    = (r_state == S_IDLE) && (i0.valid || i1.valid);
  assign w_space    = !r_c_valid || c.ready;

  assign w_g_valid  = r_sel ? i1.valid : i0.valid;
  assign w_g_last   = r_sel ? i1.last  : i0.last;
  assign w_g_data   = r_sel ? i1.data  : i0.data;
  assign w_g_ready  = r_sel ? w_i1_ready : w_i0_ready;
  assign w_fire     = w_g_valid && w_g_ready;
  assign w_last_out = w_g_last || (r_beat_cnt == C_LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_fire && w_last_out) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: only the owner may see ready, and only when the stage has room
  always_comb begin
    w_i0_ready = 1'b0;
    w_i1_ready = 1'b0;
    if (r_state == S_BUSY) begin
      w_i0_ready = !r_sel && w_space;
      w_i1_ready =  r_sel && w_space;
    end
  end

  // Grant bookkeeping and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= 1'b0;
      r_prio     <= 1'b0;
      r_beat_cnt <= '0;
      r_c_valid  <= 1'b0;
      r_c_data   <= '0;
      r_c_last   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_sel      <= w_winner;
        r_beat_cnt <= '0;
      end
      if (w_fire) begin
        r_c_valid  <= 1'b1;
        r_c_data   <= w_g_data;
        r_c_last   <= w_last_out;
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (w_last_out) begin
          r_prio <= ~r_sel;
        end
      end else if (r_c_valid && c.ready) begin
        r_c_valid <= 1'b0;
      end
    end
  end

  assign i0.ready = w_i0_ready;
  assign i1.ready = w_i1_ready;
  assign c.valid  = r_c_valid;
  assign c.data   = r_c_data;
  assign c.last   = r_c_last;
  assign sel      = r_sel;
  assign busy     = (r_state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_word_arbiter_2.sv
// ============================================================================
// Module   : tb_word_arbiter_2
// Brief    : Directed self-checking bench for word_arbiter_2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_arbiter_2;

  logic clk;
  logic rst;
  logic sel;
  logic busy;
  int   n_checks;
  int   n_errors;

  word_arbiter_2_if #(.WIDTH(32)) i0_if ();
  word_arbiter_2_if #(.WIDTH(32)) i1_if ();
  word_arbiter_2_if #(.WIDTH(32)) c_if ();

  word_arbiter_2 #(.WIDTH(32), .MAX_BEATS(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .i0   (i0_if),
    .i1   (i1_if),
    .c    (c_if),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed right after return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i0_if.valid = 1'b0; i0_if.data = '0; i0_if.last = 1'b0;
    i1_if.valid = 1'b0; i1_if.data = '0; i1_if.last = 1'b0;
    c_if.ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    // Reset state (outputs never driven yet, so zeros are meaningful)
    check("rst_sel",    32'(sel),         32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_cvalid", 32'(c_if.valid),  32'd0);
    check("rst_cdata",  c_if.data,        32'd0);
    check("rst_clast",  32'(c_if.last),   32'd0);
    check("rst_rdy0",   32'(i0_if.ready), 32'd0);
    check("rst_rdy1",   32'(i1_if.ready), 32'd0);
    rst = 1'b0;

    // 1: contention after reset, 16-beat forced release, then i1 gets the grant
    i0_if.valid = 1'b1; i1_if.valid = 1'b1;
    #1;
    check("t1_idle_busy", 32'(busy),        32'd0);
    check("t1_idle_rdy0", 32'(i0_if.ready), 32'd0);
    tick();
    check("t1_grant_sel",  32'(sel),  32'd0);
    check("t1_grant_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      i0_if.data = 32'h100 + 32'(k);
      i1_if.data = 32'h200 + 32'(k);
      tick();
      check($sformatf("t1_data%0d", k), c_if.data, 32'h100 + 32'(k));
      check($sformatf("t1_last%0d", k), 32'(c_if.last), (k == 15) ? 32'd1 : 32'd0);
    end
    check("t1_rel_busy", 32'(busy), 32'd0);
    tick();
    check("t1_sel1",  32'(sel),  32'd1);
    check("t1_busy1", 32'(busy), 32'd1);

    // 2: only i1, three-beat burst
    do_reset();
    i1_if.valid = 1'b1; i1_if.data = 32'hA5A5_0001;
    tick();
    check("t2_sel", 32'(sel), 32'd1);
    tick();
    check("t2_d1", c_if.data, 32'hA5A5_0001);
    check("t2_v1", 32'(c_if.valid), 32'd1);
    i1_if.data = 32'hA5A5_0002;
    tick();
    check("t2_d2", c_if.data, 32'hA5A5_0002);
    check("t2_l2", 32'(c_if.last), 32'd0);
    i1_if.data = 32'hA5A5_0003; i1_if.last = 1'b1;
    tick();
    check("t2_d3",   c_if.data, 32'hA5A5_0003);
    check("t2_l3",   32'(c_if.last), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    i1_if.valid = 1'b0; i1_if.last = 1'b0;
    tick();
    check("t2_drain", 32'(c_if.valid), 32'd0);

    // 3: back-pressure mid-burst
    do_reset();
    i0_if.valid = 1'b1;
    tick();
    i0_if.data = 32'h300;
    tick();
    check("t3_d0", c_if.data, 32'h300);
    i0_if.data = 32'h301; c_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_rdy0_hold%0d", k), 32'(i0_if.ready), 32'd0);
      tick();
      check($sformatf("t3_hold%0d", k), c_if.data, 32'h300);
      check($sformatf("t3_vhold%0d", k), 32'(c_if.valid), 32'd1);
    end
    c_if.ready = 1'b1;
    #1;
    check("t3_rdy0_resume", 32'(i0_if.ready), 32'd1);
    tick();
    check("t3_d1", c_if.data, 32'h301);
    i0_if.data = 32'h302; i0_if.last = 1'b1;
    tick();
    check("t3_d2", c_if.data, 32'h302);
    check("t3_l2", 32'(c_if.last), 32'd1);

    // 4: alternating two-beat bursts under constant contention
    do_reset();
    i0_if.valid = 1'b1; i1_if.valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("t4_sel_g%0d", g), 32'(sel), 32'(g % 2));
      for (int b = 0; b < 2; b++) begin
        i0_if.data = 32'h400 + 32'(g * 2 + b);
        i1_if.data = 32'h500 + 32'(g * 2 + b);
        i0_if.last = (b == 1); i1_if.last = (b == 1);
        tick();
        check($sformatf("t4_d_g%0d_b%0d", g, b), c_if.data,
              ((g % 2) == 1 ? 32'h500 : 32'h400) + 32'(g * 2 + b));
      end
      check($sformatf("t4_rel_g%0d", g), 32'(busy), 32'd0);
    end

    // 5: reset mid-burst with a word held in the output stage
    do_reset();
    i1_if.valid = 1'b1; i1_if.data = 32'h600; c_if.ready = 1'b0;
    tick();
    tick();
    check("t5_cvalid_pre", 32'(c_if.valid), 32'd1);
    check("t5_sel_pre",    32'(sel),        32'd1);
    rst = 1'b1;
    tick();
    check("t5_cvalid", 32'(c_if.valid),  32'd0);
    check("t5_sel",    32'(sel),         32'd0);
    check("t5_busy",   32'(busy),        32'd0);
    check("t5_rdy0",   32'(i0_if.ready), 32'd0);
    check("t5_rdy1",   32'(i1_if.ready), 32'd0);
    rst = 1'b0;

    // 6: owner stalls mid-burst, grant is held
    do_reset();
    i0_if.valid = 1'b1; i1_if.valid = 1'b1; i0_if.data = 32'h700;
    tick();
    tick();
    check("t6_d0", c_if.data, 32'h700);
    i0_if.valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t6_rdy1_%0d", k), 32'(i1_if.ready), 32'd0);
      tick();
      check($sformatf("t6_sel_%0d", k),  32'(sel),  32'd0);
      check($sformatf("t6_busy_%0d", k), 32'(busy), 32'd1);
    end
    i0_if.valid = 1'b1; i0_if.data = 32'h701; i0_if.last = 1'b1;
    tick();
    check("t6_d1",   c_if.data, 32'h701);
    check("t6_l1",   32'(c_if.last), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    i0_if.last = 1'b0;
    tick();
    check("t6_sel1", 32'(sel), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
